rotary_quad_gen: RTL

ROTARY_QUAD_GEN -- requirements
Module: rotary_quad_gen

---
 rtl/rotary_quad_gen_if.sv | 24 ++
 rtl/rotary_quad_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rotary_quad_gen_if.sv
// Command channel of the rotary quadrature generator: a valid/ready
// handshake carrying a direction and a detent count.
interface rotary_quad_gen_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [4:0] cmd_steps;

  // Side that issues step commands.
  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    input  cmd_ready
  );

  // Side that executes step commands (the generator).
  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/rotary_quad_gen.sv
// Rotary encoder emulator: turns a step command into a gray-coded sw/dt
// (A/B) waveform, one detent at a time, while tracking the position a
// decoder watching sw/dt would count.
module rotary_quad_gen #(
  parameter int unsigned PHASE_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  rotary_quad_gen_if.slave   cmd,
  output logic               sw,
  output logic               dt,
  output logic               busy,
  output logic               done,
  output logic [9:0]         pos
);

  // The phase counter is 16 bits wide, so the hold time must fit in it.
  if (PHASE_CYCLES < 1 || PHASE_CYCLES > 65535) begin : g_bad_phase
    $error("rotary_quad_gen: PHASE_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    PH4
  } state_t;

  localparam logic [15:0] PHASE_LAST = 16'(PHASE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  rem_q, rem_d;
  logic        dir_q, dir_d;
  logic        sw_q, sw_d;
  logic        dt_q, dt_d;
  logic        done_q, done_d;
  logic [9:0]  pos_q, pos_d;
  logic        rdy_q;

  logic        cmd_fire;
  logic        phase_end;

  // Ready only once out of reset and only when no command is in flight.
  assign cmd.cmd_ready = rdy_q && (state_q == IDLE);
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
  assign phase_end     = (cnt_q == PHASE_LAST);

  assign sw   = sw_q;
  assign dt   = dt_q;
  assign done = done_q;
  assign pos  = pos_q;
  assign busy = (state_q != IDLE);

  // Next-state, phase timing, detent bookkeeping and registered line levels.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    sw_d    = 1'b0;
    dt_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          dir_d = cmd.cmd_dir;
          if (cmd.cmd_steps == 5'd0) begin
            // Nothing to emit: acknowledge immediately, lines stay low.
            done_d = 1'b1;
          end else begin
            rem_d   = cmd.cmd_steps;
            state_d = PH1;
          end
        end
      end
      PH1: if (phase_end) state_d = PH2;
      PH2: if (phase_end) state_d = PH3;
      PH3: if (phase_end) state_d = PH4;
      PH4: begin
        if (phase_end) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PH1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every phase entry restarts the hold timer; idle keeps it parked at 0.
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 16'd1;
    end

    // Line levels follow the phase being entered so they change together
    // with the state register. CW: 10,11,01,00. CCW: 01,11,10,00.
    unique case (state_d)
      PH1:     {sw_d, dt_d} = dir_d ? 2'b01 : 2'b10;
      PH2:     {sw_d, dt_d} = 2'b11;
      PH3:     {sw_d, dt_d} = dir_d ? 2'b10 : 2'b01;
      default: {sw_d, dt_d} = 2'b00;
    endcase

    // Count on the sw rising edge, exactly as a decoder would: CW rises on
    // PH1 entry with dt low, CCW rises on PH2 entry with dt already high.
    if (!dir_d && (state_d == PH1) && (state_q != PH1)) begin
      pos_d = pos_q + 10'd1;
    end else if (dir_d && (state_d == PH2) && (state_q == PH1)) begin
      pos_d = pos_q - 10'd1;
    end
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      rem_q   <= 5'd0;
      dir_q   <= 1'b0;
      sw_q    <= 1'b0;
      dt_q    <= 1'b0;
      done_q  <= 1'b0;
      pos_q   <= 10'd0;
      rdy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      sw_q    <= sw_d;
      dt_q    <= dt_d;
      done_q  <= done_d;
      pos_q   <= pos_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule
